armleocpu_aclint: RTL

ARMLEOCPU_ACLINT -- requirements
Module: armleocpu_aclint

---
 rtl/armleocpu_aclint.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/armleocpu_aclint.sv
// Core-local interruptor: msip/mtimecmp/mtime over AXI4-Lite, per-hart software and timer interrupts.
// One access in flight; responses one cycle after accept, held until ready; complete writes beat pending reads.
module armleocpu_aclint #(
  parameter int HART_COUNT       = 7,
  parameter int HART_COUNT_WIDTH = 3,
  parameter int TIMEBASE_DIV     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           AXI_AWADDR,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,
  input  logic [31:0]           AXI_WDATA,
  input  logic [3:0]            AXI_WSTRB,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,
  input  logic [31:0]           AXI_ARADDR,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,
  output logic [31:0]           AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY,
  output logic [HART_COUNT-1:0] hart_swi,
  output logic [HART_COUNT-1:0] hart_timeri
);
  localparam int W = HART_COUNT_WIDTH;
  localparam logic [W:0]  HC      = HART_COUNT[W:0];
  localparam logic [15:0] PRE_MAX = 16'(TIMEBASE_DIV - 1);

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_CMP, SEL_TIME} sel_t;
  typedef struct packed {
    sel_t         sel;
    logic         hi;
    logic [W-1:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] addr);
    dec_t d;
    d.sel = SEL_NONE;
    d.hi  = addr[2];
    d.idx = '0;
    if (addr[31:16] == 16'h0 && addr[1:0] == 2'b00) begin
      if (addr[15:14] == 2'b00) begin
        d.idx = addr[2 +: W];
        if (addr[13:2+W] == '0 && {1'b0, addr[2 +: W]} < HC) d.sel = SEL_MSIP;
      end else if (addr[15:14] == 2'b01) begin
        d.idx = addr[3 +: W];
        if (addr[13:3+W] == '0 && {1'b0, addr[3 +: W]} < HC) d.sel = SEL_CMP;
      end else if (addr[15:3] == 13'h17FF) begin
        d.sel = SEL_TIME;
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  state_t      state, state_nxt;
  logic        wr_fire, rd_fire;
  dec_t        wdec, rdec;
  logic [15:0] prescaler;
  logic [63:0] mtime;
  logic [63:0] mtimecmp [HART_COUNT];
  logic [31:0] rd_data_nxt;
  logic [1:0]  rd_resp_nxt;

  assign wdec = decode(AXI_AWADDR);
  assign rdec = decode(AXI_ARADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (AXI_AWVALID && AXI_WVALID) begin
          wr_fire   = rst_n;
          state_nxt = WRESP;
        end else if (AXI_ARVALID) begin
          rd_fire   = rst_n;
          state_nxt = RRESP;
        end
      end
      WRESP:   if (AXI_BREADY) state_nxt = IDLE;
      RRESP:   if (AXI_RREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign AXI_AWREADY = wr_fire;
  assign AXI_WREADY  = wr_fire;
  assign AXI_ARREADY = rd_fire;
  assign AXI_BVALID  = (state == WRESP);
  assign AXI_RVALID  = (state == RRESP);

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = 2'b00;
    case (rdec.sel)
      SEL_MSIP: begin
        for (int h = 0; h < HART_COUNT; h++)
          if (rdec.idx == W'(h)) rd_data_nxt = {31'b0, hart_swi[h]};
      end
      SEL_CMP: begin
        for (int h = 0; h < HART_COUNT; h++)
          if (rdec.idx == W'(h)) rd_data_nxt = rdec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
      end
      SEL_TIME: rd_data_nxt = rdec.hi ? mtime[63:32] : mtime[31:0];
      default:  rd_resp_nxt = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AXI_BRESP <= 2'b00;
      AXI_RRESP <= 2'b00;
      AXI_RDATA <= '0;
    end else begin
      if (wr_fire) AXI_BRESP <= (wdec.sel == SEL_NONE) ? 2'b10 : 2'b00;
      if (rd_fire) begin
        AXI_RRESP <= rd_resp_nxt;
        AXI_RDATA <= rd_data_nxt;
      end
    end
  end

  // A bus write to mtime freezes the timebase for that cycle and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      mtime     <= '0;
    end else if (wr_fire && wdec.sel == SEL_TIME) begin
      prescaler <= '0;
      if (wdec.hi) mtime[63:32] <= merge(mtime[63:32], AXI_WDATA, AXI_WSTRB);
      else         mtime[31:0]  <= merge(mtime[31:0],  AXI_WDATA, AXI_WSTRB);
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      mtime     <= mtime + 64'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hart_swi    <= '0;
      hart_timeri <= '0;
      for (int h = 0; h < HART_COUNT; h++) mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < HART_COUNT; h++) begin
        hart_timeri[h] <= (mtime >= mtimecmp[h]);
        if (wr_fire && wdec.idx == W'(h)) begin
          if (wdec.sel == SEL_MSIP && AXI_WSTRB[0]) hart_swi[h] <= AXI_WDATA[0];
          if (wdec.sel == SEL_CMP) begin
            if (wdec.hi) mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], AXI_WDATA, AXI_WSTRB);
            else         mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0],  AXI_WDATA, AXI_WSTRB);
          end
        end
      end
    end
  end
endmodule
